// File: rtl/rs_defs.sv
// Shared reservation-station definitions: entry count, id/port-vector types and port indices.
package rs_defs;
   localparam int NUM_RS_ENTS  = 8;
   localparam int NUM_PORTS    = 2;
   localparam int RS_ID_W      = $clog2(NUM_RS_ENTS);
   localparam int RS_PORT_EINT = 0;
   localparam int RS_PORT_MM   = 1;

   typedef logic [RS_ID_W-1:0]   t_rs_id;
   typedef logic [NUM_PORTS-1:0] t_rs_port_vec;
endpackage

// File: rtl/rs_oldest_pick.sv
// Oldest-first selector: picks the eligible entry that no other eligible entry is older than.
module rs_oldest_pick #(
   parameter int NUM_RS_ENTS = 8
) (
   input  logic [NUM_RS_ENTS-1:0]                  elig,
   input  logic [NUM_RS_ENTS-1:0][NUM_RS_ENTS-1:0] age,
   output logic [NUM_RS_ENTS-1:0]                  win,
   output logic                                    win_vld,
   output logic [$clog2(NUM_RS_ENTS)-1:0]          win_id
);
   localparam int ID_W = $clog2(NUM_RS_ENTS);

   // age[j][i]=1 means j is older than i, so any eligible j with that bit set blocks i
   always_comb begin
      win    = '0;
      win_id = '0;
      for (int i = 0; i < NUM_RS_ENTS; i++) begin
         win[i] = elig[i];
         for (int j = 0; j < NUM_RS_ENTS; j++) begin
            if (elig[j] && age[j][i]) win[i] = 1'b0;
         end
      end
      for (int i = 0; i < NUM_RS_ENTS; i++) begin
         if (win[i]) win_id = win_id | ID_W'(i);
      end
   end

   assign win_vld = |win;
endmodule

// File: rtl/rs_age_sched.sv
// RS issue scheduler: age-matrix ordering, one oldest-ready pick per execution port,
// registered issue strobes/ids and occupancy/free-count tracking.
module rs_age_sched #(
   parameter int NUM_RS_ENTS = rs_defs::NUM_RS_ENTS,
   parameter int NUM_PORTS   = rs_defs::NUM_PORTS
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     alloc_rs0,
   input  logic [$clog2(NUM_RS_ENTS)-1:0]           alloc_id_rs0,
   input  logic [NUM_PORTS-1:0]                     alloc_port_rs0,
   input  logic [NUM_RS_ENTS-1:0]                   src_rdy_rs1,
   input  logic [NUM_PORTS-1:0]                     port_rdy_rs1,
   input  logic                                     nuke_rb1,
   output logic [NUM_PORTS-1:0]                     iss_rs2,
   output logic [NUM_PORTS*$clog2(NUM_RS_ENTS)-1:0] iss_id_rs2,
   output logic [NUM_RS_ENTS-1:0]                   ent_valid,
   output logic [$clog2(NUM_RS_ENTS):0]             free_cnt,
   output logic                                     full
);
   localparam int ID_W  = $clog2(NUM_RS_ENTS);
   localparam int CNT_W = ID_W + 1;

   logic [NUM_PORTS-1:0]                  port_q [NUM_RS_ENTS];
   logic [NUM_RS_ENTS-1:0][NUM_RS_ENTS-1:0] age_q, age_nxt;
   logic [NUM_RS_ENTS-1:0]                elig_rs1 [NUM_PORTS];
   logic [NUM_RS_ENTS-1:0]                win_rs1 [NUM_PORTS];
   logic [ID_W-1:0]                       win_id_rs1 [NUM_PORTS];
   logic [NUM_PORTS-1:0]                  win_vld_rs1;
   logic [NUM_RS_ENTS-1:0]                win_any_rs1, alloc_oh, valid_nxt;
   logic                                  alloc_go;

   function automatic logic [CNT_W-1:0] free_of(input logic [NUM_RS_ENTS-1:0] v);
      free_of = CNT_W'(NUM_RS_ENTS);
      for (int i = 0; i < NUM_RS_ENTS; i++) begin
         if (v[i]) free_of = free_of - 1'b1;
      end
   endfunction

   // rs1: eligibility and per-port oldest pick
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int i = 0; i < NUM_RS_ENTS; i++) begin
            elig_rs1[p][i] = ent_valid[i] & port_q[i][p] & src_rdy_rs1[i] & port_rdy_rs1[p];
         end
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pick
      rs_oldest_pick #(.NUM_RS_ENTS(NUM_RS_ENTS)) u_pick (
         .elig    (elig_rs1[p]),
         .age     (age_q),
         .win     (win_rs1[p]),
         .win_vld (win_vld_rs1[p]),
         .win_id  (win_id_rs1[p])
      );
   end

   // Nuke drops the same-cycle alloc; a new entry is younger than every resident one
   always_comb begin
      alloc_go              = alloc_rs0 & ~nuke_rb1;
      alloc_oh              = '0;
      alloc_oh[alloc_id_rs0] = alloc_go;
      win_any_rs1           = '0;
      for (int p = 0; p < NUM_PORTS; p++) win_any_rs1 = win_any_rs1 | win_rs1[p];
      valid_nxt = nuke_rb1 ? '0 : ((ent_valid & ~win_any_rs1) | alloc_oh);
      age_nxt   = age_q;
      if (alloc_go) begin
         age_nxt[alloc_id_rs0] = '0;
         for (int j = 0; j < NUM_RS_ENTS; j++) begin
            age_nxt[j][alloc_id_rs0] = (j != int'(alloc_id_rs0));
         end
      end
   end

   // rs2: state update and issue registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_valid  <= '0;
         age_q      <= '0;
         for (int i = 0; i < NUM_RS_ENTS; i++) port_q[i] <= '0;
         iss_rs2    <= '0;
         iss_id_rs2 <= '0;
         free_cnt   <= CNT_W'(NUM_RS_ENTS);
         full       <= 1'b0;
      end else begin
         ent_valid <= valid_nxt;
         age_q     <= age_nxt;
         if (alloc_go) port_q[alloc_id_rs0] <= alloc_port_rs0;
         free_cnt  <= free_of(valid_nxt);
         full      <= &valid_nxt;
         iss_rs2   <= nuke_rb1 ? '0 : win_vld_rs1;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (win_vld_rs1[p] && !nuke_rb1) iss_id_rs2[p*ID_W +: ID_W] <= win_id_rs1[p];
         end
      end
   end

`ifdef SIMULATION
   a_alloc_into_free: assert property (@(posedge clk) disable iff (reset)
      (alloc_rs0 && !nuke_rb1) |-> !ent_valid[alloc_id_rs0]);
`endif
endmodule

// File: tb/tb_rs_age_sched.sv
// Directed bench for rs_age_sched with a per-port scoreboard of expected issue ids.
module tb_rs_age_sched;
   import rs_defs::*;

   localparam logic [1:0] P_EINT = 2'(1 << RS_PORT_EINT);
   localparam logic [1:0] P_MM   = 2'(1 << RS_PORT_MM);

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       alloc_rs0 = 1'b0;
   logic [2:0] alloc_id_rs0 = '0;
   logic [1:0] alloc_port_rs0 = '0;
   logic [7:0] src_rdy_rs1 = '0;
   logic [1:0] port_rdy_rs1 = '0;
   logic       nuke_rb1 = 1'b0;
   logic [1:0] iss_rs2;
   logic [5:0] iss_id_rs2;
   logic [7:0] ent_valid;
   logic [3:0] free_cnt;
   logic       full;

   int checks = 0;
   int failures = 0;
   int exp_eint[$];
   int exp_mm[$];

   rs_age_sched dut (
      .clk            (clk),
      .reset          (reset),
      .alloc_rs0      (alloc_rs0),
      .alloc_id_rs0   (alloc_id_rs0),
      .alloc_port_rs0 (alloc_port_rs0),
      .src_rdy_rs1    (src_rdy_rs1),
      .port_rdy_rs1   (port_rdy_rs1),
      .nuke_rb1       (nuke_rb1),
      .iss_rs2        (iss_rs2),
      .iss_id_rs2     (iss_id_rs2),
      .ent_valid      (ent_valid),
      .free_cnt       (free_cnt),
      .full           (full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_alloc(input int id, input logic [1:0] port);
      alloc_rs0      = 1'b1;
      alloc_id_rs0   = 3'(id);
      alloc_port_rs0 = port;
      tick();
      alloc_rs0      = 1'b0;
   endtask

   task automatic drain(input string tag, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (exp_eint.size() == 0 && exp_mm.size() == 0) break;
         @(negedge clk);
         #1;
      end
      chk({tag, "_eint_left"}, exp_eint.size(), 0);
      chk({tag, "_mm_left"}, exp_mm.size(), 0);
   endtask

   // Every strobe must match the head of its port's expected queue
   always @(negedge clk) begin
      if (!reset) begin
         if (iss_rs2[0]) begin
            if (exp_eint.size() == 0) chk("eint_unexpected", int'(iss_id_rs2[2:0]), -1);
            else chk("eint_id", int'(iss_id_rs2[2:0]), exp_eint.pop_front());
         end
         if (iss_rs2[1]) begin
            if (exp_mm.size() == 0) chk("mm_unexpected", int'(iss_id_rs2[5:3]), -1);
            else chk("mm_id", int'(iss_id_rs2[5:3]), exp_mm.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (3) tick();
      chk("rst_valid", ent_valid, 0);
      chk("rst_free", free_cnt, 8);
      chk("rst_full", full, 0);
      chk("rst_iss", iss_rs2, 0);
      reset = 1'b0;
      repeat (3) begin
         tick();
         chk("idle_iss", iss_rs2, 0);
      end
      chk("idle_free", free_cnt, 8);

      // EINT age order 3,1,6 on consecutive cycles
      do_alloc(3, P_EINT);
      do_alloc(1, P_EINT);
      do_alloc(6, P_EINT);
      chk("s2_valid", ent_valid, 8'h4A);
      chk("s2_free", free_cnt, 5);
      src_rdy_rs1  = 8'hFF;
      port_rdy_rs1 = 2'b01;
      exp_eint.push_back(3);
      exp_eint.push_back(1);
      exp_eint.push_back(6);
      tick();
      chk("s2_free_a", free_cnt, 6);
      tick();
      chk("s2_free_b", free_cnt, 7);
      tick();
      chk("s2_free_c", free_cnt, 8);
      drain("s2", 10);
      src_rdy_rs1  = '0;
      port_rdy_rs1 = '0;

      // both ports in the same cycle
      do_alloc(0, P_EINT);
      do_alloc(5, P_MM);
      src_rdy_rs1  = 8'hFF;
      port_rdy_rs1 = 2'b11;
      exp_eint.push_back(0);
      exp_mm.push_back(5);
      tick();
      chk("s3_iss", iss_rs2, 3);
      chk("s3_ids", iss_id_rs2, 6'b101_000);
      drain("s3", 10);
      chk("s3_free", free_cnt, 8);
      src_rdy_rs1  = '0;
      port_rdy_rs1 = '0;

      // fill, issue one, reuse the freed id as youngest
      for (int i = 0; i < 8; i++) do_alloc(i, P_EINT);
      chk("s4_full", full, 1);
      chk("s4_free0", free_cnt, 0);
      src_rdy_rs1  = 8'h04;
      port_rdy_rs1 = 2'b01;
      exp_eint.push_back(2);
      tick();
      chk("s4_iss2", iss_rs2, 1);
      chk("s4_notfull", full, 0);
      chk("s4_free1", free_cnt, 1);
      chk("s4_valid", ent_valid, 8'hFB);
      src_rdy_rs1 = '0;
      do_alloc(2, P_EINT);
      chk("s4_refull", full, 1);
      src_rdy_rs1 = 8'hFF;
      foreach (exp_eint[k]) chk("s4_pre_empty", exp_eint[k], -1);
      exp_eint.push_back(0);
      exp_eint.push_back(1);
      exp_eint.push_back(3);
      exp_eint.push_back(4);
      exp_eint.push_back(5);
      exp_eint.push_back(6);
      exp_eint.push_back(7);
      exp_eint.push_back(2);
      drain("s4", 30);
      chk("s4_free", free_cnt, 8);
      src_rdy_rs1  = '0;
      port_rdy_rs1 = '0;

      // port back-pressure holds issue, then oldest goes first
      do_alloc(4, P_EINT);
      do_alloc(7, P_EINT);
      src_rdy_rs1 = 8'hFF;
      repeat (4) begin
         tick();
         chk("s5_blocked", iss_rs2[0], 0);
      end
      chk("s5_valid", ent_valid, 8'h90);
      port_rdy_rs1 = 2'b01;
      exp_eint.push_back(4);
      exp_eint.push_back(7);
      drain("s5", 10);
      chk("s5_free", free_cnt, 8);
      src_rdy_rs1  = '0;
      port_rdy_rs1 = '0;

      // nuke beats alloc and pick
      do_alloc(1, P_EINT);
      do_alloc(2, P_MM);
      src_rdy_rs1    = 8'hFF;
      port_rdy_rs1   = 2'b11;
      nuke_rb1       = 1'b1;
      alloc_rs0      = 1'b1;
      alloc_id_rs0   = 3'd5;
      alloc_port_rs0 = P_EINT;
      tick();
      nuke_rb1  = 1'b0;
      alloc_rs0 = 1'b0;
      chk("s6_valid", ent_valid, 0);
      chk("s6_iss", iss_rs2, 0);
      chk("s6_free", free_cnt, 8);
      chk("s6_full", full, 0);
      port_rdy_rs1 = 2'b10;
      exp_mm.push_back(3);
      do_alloc(3, P_MM);
      chk("s6_post_valid", ent_valid, 8'h08);
      drain("s6", 10);
      chk("s6_post_free", free_cnt, 8);
      src_rdy_rs1  = '0;
      port_rdy_rs1 = '0;

      // asynchronous reset mid-operation
      do_alloc(6, P_MM);
      chk("ar_valid", ent_valid, 8'h40);
      chk("ar_free", free_cnt, 7);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_valid0", ent_valid, 0);
      chk("ar_free8", free_cnt, 8);
      chk("ar_iss", iss_rs2, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("ar_after", ent_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
